// File: rtl/random_range_generator.sv
// Uniform-ish random number generator: a Fibonacci-style LFSR draw reduced modulo
// (max - min + 1) by restoring division, then offset by min.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a request; seed loads accepted here only
// S_DRAW   | advance LFSR once, latch dividend and range
// S_REDUCE | one restoring-division quotient bit per cycle (WIDTH cycles)
// S_DONE   | result held; out_valid rises one cycle after entry
module random_range_generator #(
   parameter int               WIDTH        = 16,
   parameter logic [WIDTH-1:0] TAP_MASK     = 16'hD008,
   parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(1)
) (
   input  logic                    in_clock,
   input  logic                    in_reset,
   input  logic                    in_seed_load,
   input  logic        [WIDTH-1:0] in_seed,
   input  logic                    in_request,
   input  logic signed [WIDTH-1:0] in_min,
   input  logic signed [WIDTH-1:0] in_max,
   input  logic                    in_ready,
   output logic                    out_busy,
   output logic                    out_valid,
   output logic signed [WIDTH-1:0] out_random,
   output logic                    out_error
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_DRAW, S_REDUCE, S_DONE} state_t;

   state_t                    r_state;
   state_t                    w_next_state;
   logic        [WIDTH-1:0]   r_lfsr;
   logic signed [WIDTH-1:0]   r_min;
   logic signed [WIDTH-1:0]   r_max;
   logic        [WIDTH:0]     r_range;
   logic        [WIDTH-1:0]   r_rem;
   logic        [WIDTH-1:0]   r_dividend;
   logic        [CW-1:0]      r_count;
   logic                      r_valid;
   logic                      r_error;
   logic signed [WIDTH-1:0]   r_random;

   logic        [WIDTH-1:0]   w_lfsr_step;
   logic        [WIDTH-1:0]   w_seed_fixed;
   logic                      w_bad_range;
   logic        [WIDTH:0]     w_range;
   logic        [WIDTH:0]     w_trial;
   logic        [WIDTH-1:0]   w_rem_next;
   logic        [WIDTH-1:0]   w_result;

   assign w_lfsr_step  = {r_lfsr[WIDTH-2:0], ^(r_lfsr & TAP_MASK)};
   assign w_seed_fixed = (in_seed == '0) ? WIDTH'(1) : in_seed;
   assign w_bad_range  = (in_min > in_max);

   // Sign-extended difference in WIDTH+1 bits so a full 2^WIDTH span is exact.
   assign w_range    = {r_max[WIDTH-1], r_max} - {r_min[WIDTH-1], r_min} + (WIDTH+1)'(1);
   assign w_trial    = {r_rem, r_dividend[WIDTH-1]};
   assign w_rem_next = WIDTH'((w_trial >= r_range) ? (w_trial - r_range) : w_trial);
   assign w_result   = r_min + w_rem_next;

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (in_request) w_next_state = w_bad_range ? S_DONE : S_DRAW;
         S_DRAW:   w_next_state = S_REDUCE;
         S_REDUCE: if (r_count == '0) w_next_state = S_DONE;
         S_DONE:   if (r_valid && in_ready) w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge in_clock) begin
      if (in_reset) begin
         r_state    <= S_IDLE;
         r_lfsr     <= SEED_DEFAULT;
         r_min      <= '0;
         r_max      <= '0;
         r_range    <= '0;
         r_rem      <= '0;
         r_dividend <= '0;
         r_count    <= '0;
         r_valid    <= 1'b0;
         r_error    <= 1'b0;
         r_random   <= '0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            S_IDLE: begin
               if (in_seed_load) r_lfsr <= w_seed_fixed;
               if (in_request) begin
                  r_min   <= in_min;
                  r_max   <= in_max;
                  r_error <= w_bad_range;
                  if (w_bad_range) r_random <= in_min;
               end
            end
            S_DRAW: begin
               r_lfsr     <= w_lfsr_step;
               r_dividend <= w_lfsr_step;
               r_rem      <= '0;
               r_range    <= w_range;
               r_count    <= CW'(WIDTH - 1);
            end
            S_REDUCE: begin
               r_rem      <= w_rem_next;
               r_dividend <= {r_dividend[WIDTH-2:0], 1'b0};
               if (r_count == '0) r_random <= w_result;
               else               r_count  <= r_count - 1'b1;
            end
            S_DONE: begin
               // out_valid lags DONE entry by one cycle to give the fixed latency.
               if (!r_valid)      r_valid <= 1'b1;
               else if (in_ready) r_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign out_busy   = (r_state != S_IDLE);
   assign out_valid  = r_valid;
   assign out_random = r_random;
   assign out_error  = r_error;

endmodule

// File: tb/tb_random_range_generator.sv
// Self-checking bench for random_range_generator: directed cases plus randomized
// requests against an arithmetic reference model (LFSR step, then % range).
module tb_random_range_generator;
   localparam int W = 16;
   localparam logic [W-1:0] TAPS = 16'hD008;

   logic                in_clock = 1'b0;
   logic                in_reset = 1'b1;
   logic                in_seed_load = 1'b0;
   logic        [W-1:0] in_seed = '0;
   logic                in_request = 1'b0;
   logic signed [W-1:0] in_min = '0;
   logic signed [W-1:0] in_max = '0;
   logic                in_ready = 1'b0;
   logic                out_busy;
   logic                out_valid;
   logic signed [W-1:0] out_random;
   logic                out_error;

   int checks = 0;
   int failures = 0;
   logic [W-1:0] m_lfsr;

   random_range_generator #(.WIDTH(W)) dut (
      .in_clock(in_clock), .in_reset(in_reset), .in_seed_load(in_seed_load),
      .in_seed(in_seed), .in_request(in_request), .in_min(in_min), .in_max(in_max),
      .in_ready(in_ready), .out_busy(out_busy), .out_valid(out_valid),
      .out_random(out_random), .out_error(out_error)
   );

   always #5 in_clock = ~in_clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge in_clock);
      #1;
   endtask

   function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] v);
      logic fb;
      fb = 1'b0;
      for (int i = 0; i < W; i++) if (TAPS[i]) fb = fb ^ v[i];
      return (v << 1) | W'(fb);
   endfunction

   task automatic do_request(input logic signed [W-1:0] mn, input logic signed [W-1:0] mx,
                             input bit load, input logic [W-1:0] seed,
                             input int ready_delay, input bit noise, input string tag);
      int          exp_lat;
      int          n;
      logic [W-1:0] exp_rand;
      logic         exp_err;
      longint       rng;
      longint       rem;
      logic [W-1:0] got;
      logic         in_rng;

      if (load) m_lfsr = (seed == '0) ? W'(1) : seed;
      if (mn > mx) begin
         exp_err  = 1'b1;
         exp_rand = mn;
         exp_lat  = 1;
      end else begin
         m_lfsr   = lfsr_next(m_lfsr);
         rng      = longint'(mx) - longint'(mn) + 1;
         rem      = longint'(m_lfsr) % rng;
         exp_rand = W'(longint'(mn) + rem);
         exp_err  = 1'b0;
         exp_lat  = W + 2;
      end

      in_min = mn; in_max = mx; in_seed = seed; in_seed_load = load; in_request = 1'b1;
      tick;
      in_request = 1'b0; in_seed_load = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin
         tick;
         n++;
      end
      check({tag, " latency"}, 64'(n), 64'(exp_lat));
      got = out_random;
      check({tag, " random"}, 64'(got), 64'(exp_rand));
      check({tag, " error"}, 64'(out_error), 64'(exp_err));
      check({tag, " lfsr"}, 64'(dut.r_lfsr), 64'(m_lfsr));
      if (!exp_err) begin
         in_rng = (out_random >= mn) && (out_random <= mx);
         check({tag, " in_range"}, 64'(in_rng), 64'd1);
      end

      for (int c = 0; c < ready_delay; c++) begin
         if (noise) begin
            in_request   = c[0];
            in_seed_load = ~c[0];
            in_seed      = 16'h1234;
            in_min       = 7;
            in_max       = 9;
         end
         tick;
         if (noise) begin
            got = out_random;
            check({tag, " hold valid"}, 64'(out_valid), 64'd1);
            check({tag, " hold random"}, 64'(got), 64'(exp_rand));
            check({tag, " hold error"}, 64'(out_error), 64'(exp_err));
            check({tag, " hold lfsr"}, 64'(dut.r_lfsr), 64'(m_lfsr));
         end
      end
      in_request = 1'b0; in_seed_load = 1'b0;

      in_ready = 1'b1;
      tick;
      in_ready = 1'b0;
      got = out_random;
      check({tag, " post valid"}, 64'(out_valid), 64'd0);
      check({tag, " post busy"}, 64'(out_busy), 64'd0);
      check({tag, " post random"}, 64'(got), 64'(exp_rand));
   endtask

   initial begin
      logic [W-1:0] got;
      int           vcount;
      int           mode;
      int           base;
      int           span;
      logic signed [W-1:0] mn;
      logic signed [W-1:0] mx;
      bit           ld;
      logic [W-1:0] sd;

      in_reset = 1'b1;
      tick;
      tick;
      got = out_random;
      check("reset busy", 64'(out_busy), 64'd0);
      check("reset valid", 64'(out_valid), 64'd0);
      check("reset error", 64'(out_error), 64'd0);
      check("reset random", 64'(got), 64'd0);
      check("reset lfsr", 64'(dut.r_lfsr), 64'd1);
      m_lfsr = 16'h0001;
      in_reset = 1'b0;
      tick;

      do_request(16'sd0, 16'sd9, 1'b1, 16'h0001, 0, 1'b0, "small");
      do_request(-16'sd32768, 16'sd32767, 1'b1, 16'h0001, 0, 1'b0, "full");
      do_request(16'sd5, 16'sd5, 1'b1, 16'h0000, 1, 1'b0, "single");
      do_request(16'sd3, 16'sd1, 1'b0, 16'h0000, 0, 1'b0, "err");
      do_request(16'sd10, 16'sd100, 1'b0, 16'h0000, 10, 1'b1, "hold");
      do_request(-16'sd50, 16'sd50, 1'b0, 16'h0000, 0, 1'b0, "after_hold");

      // Reset in the middle of REDUCE must drop the request silently.
      in_min = 0; in_max = 1000; in_request = 1'b1;
      tick;
      in_request = 1'b0;
      repeat (5) tick;
      check("midreset busy_before", 64'(out_busy), 64'd1);
      in_reset = 1'b1;
      tick;
      in_reset = 1'b0;
      check("midreset busy", 64'(out_busy), 64'd0);
      check("midreset valid", 64'(out_valid), 64'd0);
      check("midreset lfsr", 64'(dut.r_lfsr), 64'd1);
      m_lfsr = 16'h0001;
      vcount = 0;
      repeat (30) begin
         tick;
         if (out_valid) vcount++;
      end
      check("midreset no_result", 64'(vcount), 64'd0);

      for (int i = 0; i < 1000; i++) begin
         mode = $urandom_range(0, 9);
         if (mode <= 5) begin
            base = $urandom_range(0, 65535) - 32768;
            span = $urandom_range(0, (mode < 3) ? 20 : 3000);
            if (base + span > 32767) span = 32767 - base;
            mn = W'(base);
            mx = W'(base + span);
         end else if (mode <= 7) begin
            mn = W'($urandom);
            mx = W'($urandom);
         end else if (mode == 8) begin
            base = $urandom_range(0, 65534) - 32767;
            mn = W'(base);
            mx = W'(base - $urandom_range(1, base + 32768));
         end else begin
            mn = -16'sd32768;
            mx = 16'sd32767;
         end
         ld = ($urandom_range(0, 7) == 0);
         sd = ($urandom_range(0, 3) == 0) ? 16'h0000 : W'($urandom);
         do_request(mn, mx, ld, sd, $urandom_range(0, 3), 1'b0, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/random_range_generator.md
RANDOM_RANGE_GENERATOR -- requirements
Module: random_range_generator

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the LFSR and output width (4..32).
REQ-002 SHALL have parameter TAP_MASK, default 16'hD008, giving the feedback taps (x^16+x^15+x^13+x^4+1).
REQ-003 SHALL have parameter SEED_DEFAULT, default 1, giving the nonzero LFSR value loaded at reset.
REQ-004 SHALL have one clock and a synchronous, active-high reset: in_clock input 1 (all state changes on its rising edge); in_reset input 1 (synchronous, active-high).
REQ-005 SHALL have port in_seed_load, input, 1 bit: load in_seed into the LFSR.
REQ-006 SHALL have port in_seed, input, WIDTH bits: seed value, unsigned.
REQ-007 SHALL have port in_request, input, 1 bit: request one random number.
REQ-008 SHALL have port in_min, input, WIDTH bits signed: inclusive range minimum.
REQ-009 SHALL have port in_max, input, WIDTH bits signed: inclusive range maximum.
REQ-010 SHALL have port in_ready, input, 1 bit: consumer accepts the held result.
REQ-011 SHALL have port out_busy, output, 1 bit: high in any state other than IDLE.
REQ-012 SHALL have port out_valid, output, 1 bit: out_random and out_error are valid.
REQ-013 SHALL have port out_random, output, WIDTH bits signed: result in [in_min, in_max].
REQ-014 SHALL have port out_error, output, 1 bit: the request had in_min > in_max.

Function
REQ-015 SHALL implement FSM states IDLE, DRAW, REDUCE, DONE.
REQ-016 SHALL advance the LFSR only in DRAW: next = {lfsr[WIDTH-2:0], ^(lfsr & TAP_MASK)}.
REQ-017 SHALL, in IDLE with in_request=1, capture in_min/in_max and go to DRAW, or go to DONE if in_min > in_max (signed compare).
REQ-018 SHALL ignore in_request and in_seed_load outside IDLE.
REQ-019 SHALL, on in_seed_load in IDLE, load in_seed, substituting 1 when in_seed==0, so the LFSR never locks up.
REQ-020 SHALL, on simultaneous in_seed_load and in_request in IDLE, load the seed at that edge and draw from the seeded value in DRAW.
REQ-021 SHALL compute range = max - min + 1 in WIDTH+1 unsigned bits, so a full range of 2^WIDTH is exact.
REQ-022 SHALL reduce the drawn LFSR value modulo range by restoring division, one quotient bit per cycle, WIDTH cycles in REDUCE.
REQ-023 SHALL set out_random = min + remainder, which fits in WIDTH signed bits because it never exceeds max.
REQ-024 SHALL give fixed latency for a valid request accepted at edge k: DRAW at k+1, REDUCE at k+2..k+WIDTH+1, out_valid=1 after edge k+WIDTH+2.
REQ-025 SHALL, for an error request accepted at edge k, assert out_valid after edge k+1 with out_error=1, out_random=in_min, and no LFSR advance.
REQ-026 SHALL, in DONE, hold out_valid, out_random and out_error stable until an edge with in_ready=1, then return to IDLE with out_valid=0.
REQ-027 SHALL leave out_random holding the last result after the handshake; out_error is cleared at the next accept.
REQ-028 SHALL accept a new request at the earliest one edge after the handshake, giving no back-to-back overlap.

Reset
REQ-029 SHALL, with in_reset=1 at an edge, enter IDLE with lfsr=SEED_DEFAULT, out_valid=0, out_error=0, out_random=0, out_busy=0.
REQ-030 SHALL give reset priority over all other inputs and, mid-operation, abandon the request with no out_valid.

Verification
REQ-031 SHALL cover: WIDTH=16, reset, seed 16'h0001, request min=0 max=9 -> LFSR 16'h0002, out_random=2 at edge k+18, out_error=0.
REQ-032 SHALL cover: seed 16'h0001, request min=-32768 max=32767 -> out_random=-32766; then seed 0 plus request min=5 max=5 -> out_random=5 and LFSR=16'h0002.
REQ-033 SHALL cover: request min=3 max=1 -> out_valid after edge k+1, out_error=1, out_random=3, LFSR unchanged.
REQ-034 SHALL cover: in_ready=0 for 10 cycles after out_valid, with in_request and in_seed_load pulsed -> outputs frozen, LFSR unchanged, both pulses ignored.
REQ-035 SHALL cover: in_reset during REDUCE -> next cycle IDLE, out_valid=0, LFSR=SEED_DEFAULT, no result emitted.
REQ-036 SHALL cover: 1000 random requests with a reference model -> every result in [min, max] and bit-exact to the model.
